lpc_cycle_decoder: RTL and testbench

LPC_CYCLE_DECODER -- requirements
Module: lpc_cycle_decoder

---
 rtl/lpc_pkg.sv | 38 +++
 rtl/lpc_cycle_decoder_if.sv | 26 ++
 rtl/lpc_sync_timer.sv | 29 ++
 rtl/lpc_cycle_decoder.sv | 156 +++++++++++++++
 tb/tb_lpc_cycle_decoder.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/lpc_pkg.sv
// Shared LPC decoder definitions: FSM states, cycle-type, SYNC and framing nibbles.
package lpc_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CYCTYPE,
        ST_ADDR,
        ST_WDATA,
        ST_TAR1,
        ST_TAR2,
        ST_SYNC,
        ST_RDATA,
        ST_TAREND1,
        ST_TAREND2
    } lpc_state_e;

    // Cycle type in [3:2], direction in [1] (1 = write), [0] reserved.
    localparam logic [3:0] IO_RD  = 4'b0000;
    localparam logic [3:0] IO_WR  = 4'b0010;
    localparam logic [3:0] MEM_RD = 4'b0100;
    localparam logic [3:0] MEM_WR = 4'b0110;

    localparam logic [1:0] TYPE_IO  = 2'b00;
    localparam logic [1:0] TYPE_MEM = 2'b01;

    localparam logic [3:0] READY      = 4'b0000;
    localparam logic [3:0] SHORT_WAIT = 4'b0101;
    localparam logic [3:0] LONG_WAIT  = 4'b0110;
    localparam logic [3:0] ERROR      = 4'b1010;

    localparam logic [3:0] START = 4'b0000;
    localparam logic [3:0] ABORT = 4'b1111;

    function automatic logic [2:0] last_addr_nibble(input logic mem);
        return mem ? 3'd7 : 3'd3;
    endfunction

endpackage

// File: rtl/lpc_cycle_decoder_if.sv
// LPC bus plus captured-cycle report; master drives LFRAME#/LAD, slave is the decoder.
interface lpc_cycle_decoder_if;

    logic        lpc_frame;
    logic [3:0]  lpc_ad;
    logic [3:0]  out_cyctype_dir;
    logic [31:0] out_addr;
    logic [7:0]  out_data;
    logic [3:0]  out_sync;
    logic        out_valid;
    logic        out_sync_timeout;
    logic        out_abort;

    modport master (
        output lpc_frame, lpc_ad,
        input  out_cyctype_dir, out_addr, out_data, out_sync,
        input  out_valid, out_sync_timeout, out_abort
    );

    modport slave (
        input  lpc_frame, lpc_ad,
        output out_cyctype_dir, out_addr, out_data, out_sync,
        output out_valid, out_sync_timeout, out_abort
    );

endinterface

// File: rtl/lpc_sync_timer.sv
// SYNC wait counter: clear has priority, increment when asked, otherwise hold.
module lpc_sync_timer #(
    parameter int SYNC_TIMEOUT = 32,
    parameter int CNT_W        = 6
) (
    input  logic lpc_clock,
    input  logic lpc_reset,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(SYNC_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc)
            cnt <= cnt + 1'b1;
    end

    // High on the increment that brings the count up to SYNC_TIMEOUT.
    assign expire = inc && (cnt == LAST);

endmodule

// File: rtl/lpc_cycle_decoder.sv
// LPC target-side cycle decoder (I/O, optionally memory) with SYNC timeout and abort.
// Define LPC_DECODER_MEM_CYCLES_EN to build memory read/write decoding and a 32-bit address path.
module lpc_cycle_decoder
    import lpc_pkg::*;
#(
    parameter int SYNC_TIMEOUT = 32,
    parameter int CNT_W        = 6
) (
    input  logic               lpc_clock,
    input  logic               lpc_reset,
    lpc_cycle_decoder_if.slave bus
);

`ifdef LPC_DECODER_MEM_CYCLES_EN
    localparam int   ADDR_W = 32;
    localparam logic MEM_EN = 1'b1;
`else
    localparam int   ADDR_W = 16;
    localparam logic MEM_EN = 1'b0;
`endif

    lpc_state_e        state;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        nib;
    logic              is_mem;
    logic              is_wr;
    logic              armed;
    logic              frame;
    logic [3:0]        ad;
    logic              sync_active;
    logic              timer_clr;
    logic              timer_inc;
    logic              timer_expire;

    assign frame = bus.lpc_frame;
    assign ad    = bus.lpc_ad;

    // I/O cycles shift only 4 nibbles into a cleared register, so the top half stays zero.
    assign bus.out_addr = 32'(addr);

    assign sync_active = (state == ST_SYNC) && frame;
    assign timer_inc   = sync_active && !(ad == READY || ad == ERROR || ad == LONG_WAIT);
    assign timer_clr   = !sync_active || (ad == LONG_WAIT);

    lpc_sync_timer #(
        .SYNC_TIMEOUT(SYNC_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_sync_timer (
        .lpc_clock(lpc_clock),
        .lpc_reset(lpc_reset),
        .clr      (timer_clr),
        .inc      (timer_inc),
        .expire   (timer_expire)
    );

    // Low only on the reset-release edge, so no pulse can leave on that edge.
    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) armed <= 1'b0;
        else            armed <= 1'b1;
    end

    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            state                <= ST_IDLE;
            addr                 <= '0;
            nib                  <= '0;
            is_mem               <= 1'b0;
            is_wr                <= 1'b0;
            bus.out_cyctype_dir  <= '0;
            bus.out_data         <= '0;
            bus.out_sync         <= '0;
            bus.out_valid        <= 1'b0;
            bus.out_abort        <= 1'b0;
            bus.out_sync_timeout <= 1'b0;
        end else begin
            bus.out_valid        <= 1'b0;
            bus.out_abort        <= 1'b0;
            bus.out_sync_timeout <= 1'b0;
            if (!frame) begin
                if (ad == START) begin
                    state        <= ST_CYCTYPE;
                    addr         <= '0;
                    nib          <= '0;
                    bus.out_data <= '0;
                    bus.out_sync <= '0;
                end else begin
                    state <= ST_IDLE;
                    if (ad == ABORT && state != ST_IDLE && state != ST_CYCTYPE)
                        bus.out_abort <= armed;
                end
            end else begin
                unique case (state)
                    ST_IDLE: ;
                    ST_CYCTYPE: begin
                        bus.out_cyctype_dir <= ad;
                        is_mem              <= (ad[3:2] == TYPE_MEM);
                        is_wr               <= ad[1];
                        nib                 <= '0;
                        // Decode the nibble on the wire; the latched copy is not valid yet.
                        if (ad[3:2] == TYPE_IO || (MEM_EN && ad[3:2] == TYPE_MEM))
                            state <= ST_ADDR;
                        else
                            state <= ST_IDLE;
                    end
                    ST_ADDR: begin
                        addr <= {addr[ADDR_W-5:0], ad};
                        nib  <= nib + 3'd1;
                        if (nib == last_addr_nibble(is_mem)) begin
                            nib   <= '0;
                            state <= is_wr ? ST_WDATA : ST_TAR1;
                        end
                    end
                    ST_WDATA: begin
                        if (nib == 3'd0) begin
                            bus.out_data[3:0] <= ad;
                            nib               <= 3'd1;
                        end else begin
                            bus.out_data[7:4] <= ad;
                            nib               <= '0;
                            state             <= ST_TAR1;
                        end
                    end
                    ST_TAR1: state <= ST_TAR2;
                    ST_TAR2: state <= ST_SYNC;
                    ST_SYNC: begin
                        if (ad == READY || ad == ERROR) begin
                            bus.out_sync <= ad;
                            nib          <= '0;
                            state        <= is_wr ? ST_TAREND1 : ST_RDATA;
                        end else if (timer_expire) begin
                            bus.out_sync_timeout <= armed;
                            state                <= ST_IDLE;
                        end
                    end
                    ST_RDATA: begin
                        if (nib == 3'd0) begin
                            bus.out_data[3:0] <= ad;
                            nib               <= 3'd1;
                        end else begin
                            bus.out_data[7:4] <= ad;
                            nib               <= '0;
                            state             <= ST_TAREND1;
                        end
                    end
                    ST_TAREND1: state <= ST_TAREND2;
                    ST_TAREND2: begin
                        bus.out_valid <= armed;
                        state         <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lpc_cycle_decoder.sv
// Directed bench for lpc_cycle_decoder: transaction-level model predicts pulses and captured fields.
module tb_lpc_cycle_decoder;
    import lpc_pkg::*;

    localparam int TO = 32;
`ifdef LPC_DECODER_MEM_CYCLES_EN
    localparam bit MEM_EN = 1'b1;
`else
    localparam bit MEM_EN = 1'b0;
`endif

    typedef enum {EV_NONE, EV_VALID, EV_ABORT, EV_TO} ev_e;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    lpc_cycle_decoder_if bus();

    lpc_cycle_decoder #(.SYNC_TIMEOUT(TO), .CNT_W(6)) dut (
        .lpc_clock(clk),
        .lpc_reset(rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int tests   = 0;
    int fails   = 0;
    int n_valid = 0;
    int n_abort = 0;
    int n_to    = 0;
    bit chk_en  = 1'b0;

    logic        exp_valid = 1'b0;
    logic        exp_abort = 1'b0;
    logic        exp_to    = 1'b0;
    logic [3:0]  exp_cyc   = '0;
    logic [3:0]  exp_sync  = '0;
    logic [31:0] exp_addr  = '0;
    logic [7:0]  exp_data  = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // One compare process: pulses every cycle, captured fields whenever a cycle completes.
    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
            check("out_abort", 32'(bus.out_abort), 32'(exp_abort));
            check("out_sync_timeout", 32'(bus.out_sync_timeout), 32'(exp_to));
            check("pulse_exclusive",
                  32'($onehot0({bus.out_valid, bus.out_abort, bus.out_sync_timeout})), 32'd1);
            if (exp_valid) begin
                check("cyctype", 32'(bus.out_cyctype_dir), 32'(exp_cyc));
                check("addr", bus.out_addr, exp_addr);
                check("data", 32'(bus.out_data), 32'(exp_data));
                check("sync", 32'(bus.out_sync), 32'(exp_sync));
            end
            n_valid += int'(bus.out_valid);
            n_abort += int'(bus.out_abort);
            n_to    += int'(bus.out_sync_timeout);
        end
    end

    task automatic step(input logic f, input logic [3:0] a, input ev_e ev);
        bus.lpc_frame = f;
        bus.lpc_ad    = a;
        @(posedge clk);
        exp_valid = (ev == EV_VALID);
        exp_abort = (ev == EV_ABORT);
        exp_to    = (ev == EV_TO);
        #1;
    endtask

    // Drives a whole cycle and predicts its outcome from the protocol rules.
    task automatic lpc_cycle(input logic [3:0] cyc, input logic [31:0] a, input logic [7:0] d,
                             input logic [3:0] wcode, input int nwait, input logic [3:0] fin);
        bit mem  = (cyc[3:2] == 2'b01);
        bit live = (cyc[3:2] == 2'b00) || (mem && MEM_EN);
        bit wr   = cyc[1];
        int na   = mem ? 8 : 4;
        step(1'b0, START, EV_NONE);
        step(1'b1, cyc, EV_NONE);
        check("state_after_cyctype", 32'(dut.state), live ? 32'(ST_ADDR) : 32'(ST_IDLE));
        for (int i = na - 1; i >= 0; i--) step(1'b1, a[4*i +: 4], EV_NONE);
        if (wr) begin
            step(1'b1, d[3:0], EV_NONE);
            step(1'b1, d[7:4], EV_NONE);
        end
        step(1'b1, 4'hF, EV_NONE);
        step(1'b1, 4'hF, EV_NONE);
        for (int i = 0; i < nwait; i++) begin
            if (live && wcode != LONG_WAIT && i + 1 == TO) begin
                step(1'b1, wcode, EV_TO);
                return;
            end
            step(1'b1, wcode, EV_NONE);
        end
        step(1'b1, fin, EV_NONE);
        if (!wr) begin
            step(1'b1, d[3:0], EV_NONE);
            step(1'b1, d[7:4], EV_NONE);
        end
        step(1'b1, 4'hF, EV_NONE);
        if (live) begin
            exp_cyc  = cyc;
            exp_addr = mem ? a : {16'h0, a[15:0]};
            exp_data = d;
            exp_sync = fin;
        end
        step(1'b1, 4'hF, live ? EV_VALID : EV_NONE);
    endtask

    initial begin
        bus.lpc_frame = 1'b1;
        bus.lpc_ad    = 4'hF;
        #2 rst_n = 1'b0;
        #20;
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_abort", 32'(bus.out_abort), 32'd0);
        check("rst_timeout", 32'(bus.out_sync_timeout), 32'd0);
        check("rst_addr", bus.out_addr, 32'd0);
        check("rst_data", 32'(bus.out_data), 32'd0);
        check("rst_cyctype", 32'(bus.out_cyctype_dir), 32'd0);
        check("rst_sync", 32'(bus.out_sync), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 chk_en = 1'b1;

        // I/O read 0x0080, data 0x5A
        lpc_cycle(IO_RD, 32'h0000_0080, 8'h5A, SHORT_WAIT, 0, READY);
        check("lit_rd_addr", bus.out_addr, 32'h0000_0080);
        check("lit_rd_data", 32'(bus.out_data), 32'h5A);
        check("lit_rd_cyc", 32'(bus.out_cyctype_dir), 32'h0);
        check("lit_rd_sync", 32'(bus.out_sync), 32'h0);

        // I/O write 0x002E, data 0x13, three short waits
        lpc_cycle(IO_WR, 32'h0000_002E, 8'h13, SHORT_WAIT, 3, READY);
        check("lit_wr_cyc", 32'(bus.out_cyctype_dir), 32'b0010);
        check("lit_wr_data", 32'(bus.out_data), 32'h13);
        check("lit_wr_addr", bus.out_addr, 32'h0000_002E);

        // Error SYNC is captured and still completes the cycle
        lpc_cycle(IO_RD, 32'h0000_BEEF, 8'hC3, SHORT_WAIT, 2, ERROR);
        check("lit_err_sync", 32'(bus.out_sync), 32'b1010);

        // Memory cycles: decoded only when the macro is defined
        lpc_cycle(MEM_RD, 32'hFFFF_FFF0, 8'h77, SHORT_WAIT, 1, READY);
        check("lit_mem_addr", bus.out_addr, MEM_EN ? 32'hFFFF_FFF0 : 32'h0);
        check("mem_end_idle", 32'(dut.state), 32'(ST_IDLE));
        lpc_cycle(MEM_WR, 32'h1234_5678, 8'hA5, SHORT_WAIT, 0, READY);

        // Invalid cycle type drops to IDLE
        lpc_cycle(4'b1000, 32'h0000_0010, 8'h00, SHORT_WAIT, 0, READY);

        // SYNC timeout at exactly TO no-response clocks; TO-1 still completes
        lpc_cycle(IO_RD, 32'h0000_0060, 8'h00, 4'hF, TO, READY);
        lpc_cycle(IO_RD, 32'h0000_0060, 8'h11, 4'hF, TO - 1, READY);
        lpc_cycle(IO_RD, 32'h0000_0064, 8'h22, LONG_WAIT, 100, READY);
        lpc_cycle(IO_WR, 32'h0000_0070, 8'h33, SHORT_WAIT, TO, READY);

        // Abort on the 3rd address nibble, then a normal cycle
        step(1'b0, START, EV_NONE);
        step(1'b1, IO_RD, EV_NONE);
        step(1'b1, 4'h0, EV_NONE);
        step(1'b1, 4'h3, EV_NONE);
        step(1'b0, ABORT, EV_ABORT);
        lpc_cycle(IO_RD, 32'h0000_03F8, 8'h9C, SHORT_WAIT, 0, READY);

        // Abort code while idle and a foreign start code mid-cycle are silent
        step(1'b0, ABORT, EV_NONE);
        step(1'b1, 4'hF, EV_NONE);
        step(1'b0, START, EV_NONE);
        step(1'b1, IO_WR, EV_NONE);
        step(1'b1, 4'h1, EV_NONE);
        step(1'b0, 4'h2, EV_NONE);
        check("foreign_start_idle", 32'(dut.state), 32'(ST_IDLE));
        step(1'b1, 4'h0, EV_NONE);
        step(1'b1, 4'h0, EV_NONE);

        // Extended LFRAME#: START held for two clocks
        step(1'b0, START, EV_NONE);
        lpc_cycle(IO_WR, 32'h0000_0080, 8'hF0, SHORT_WAIT, 1, READY);

        // Reset asserted during RDATA
        step(1'b0, START, EV_NONE);
        step(1'b1, IO_RD, EV_NONE);
        step(1'b1, 4'h1, EV_NONE);
        step(1'b1, 4'h2, EV_NONE);
        step(1'b1, 4'h3, EV_NONE);
        step(1'b1, 4'h4, EV_NONE);
        step(1'b1, 4'hF, EV_NONE);
        step(1'b1, 4'hF, EV_NONE);
        step(1'b1, ERROR, EV_NONE);
        step(1'b1, 4'h7, EV_NONE);
        check("pre_rst_addr", bus.out_addr, 32'h0000_1234);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_addr", bus.out_addr, 32'd0);
        check("mid_rst_data", 32'(bus.out_data), 32'd0);
        check("mid_rst_sync", 32'(bus.out_sync), 32'd0);
        check("mid_rst_cyc", 32'(bus.out_cyctype_dir), 32'd0);
        check("mid_rst_pulses", 32'({bus.out_valid, bus.out_abort, bus.out_sync_timeout}), 32'd0);
        check("mid_rst_state", 32'(dut.state), 32'(ST_IDLE));
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        lpc_cycle(IO_RD, 32'h0000_02F8, 8'hE1, SHORT_WAIT, 1, READY);
        check("lit_post_rst_data", 32'(bus.out_data), 32'hE1);

        for (int i = 0; i < 4; i++) step(1'b1, 4'hF, EV_NONE);
        check("valid_count", 32'(n_valid), MEM_EN ? 32'd10 : 32'd8);
        check("abort_count", 32'(n_abort), 32'd1);
        check("timeout_count", 32'(n_to), 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
